// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle controller: FSM states,
// instruction classes, opcodes and datapath select encodings.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_OPIMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_ILLEGAL
    } op_class_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MDR = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

endpackage

// File: rtl/opcode_classifier.sv
// Maps IR[6:0] to an instruction class; the extended opcodes are illegal
// unless ENABLE_EXT is set.
module opcode_classifier
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_EXT = 1'b1
) (
    input  logic [6:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        // NOTE: op_class is assigned before the case so no path can infer a latch.
        op_class = CLS_ILLEGAL;
        case (opcode)
            OPC_R:      op_class = CLS_R;
            OPC_LOAD:   op_class = CLS_LOAD;
            OPC_STORE:  op_class = CLS_STORE;
            OPC_BRANCH: op_class = CLS_BRANCH;
            OPC_IMM:    if (ENABLE_EXT) op_class = CLS_OPIMM;
            OPC_JAL:    if (ENABLE_EXT) op_class = CLS_JAL;
            OPC_JALR:   if (ENABLE_EXT) op_class = CLS_JALR;
            OPC_LUI:    if (ENABLE_EXT) op_class = CLS_LUI;
            OPC_AUIPC:  if (ENABLE_EXT) op_class = CLS_AUIPC;
            default:    op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/wb over one
// shared memory port and ALU, with a memory-ready timeout and illegal-opcode trap.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter bit          ENABLE_EXT = 1'b1,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic [1:0] alu_src_a,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       fault,
    output logic [2:0] state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state_q;
    op_class_t        class_q;
    op_class_t        decoded;
    logic [CNT_W-1:0] cnt_q;
    logic             last_wait;

    opcode_classifier #(.ENABLE_EXT(ENABLE_EXT)) u_classifier (
        .opcode   (opcode),
        .op_class (decoded)
    );

    // A low mem_ready in this cycle brings the wait count up to TIMEOUT.
    assign last_wait = (cnt_q == CNT_W'(TIMEOUT - 1));

    // The wait counter idles at zero, so it is already clear whenever FETCH or
    // MEM is entered and only counts while an access is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            class_q <= CLS_R;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the old values.
            cnt_q <= '0;
            case (state_q)
                ST_IDLE: state_q <= ST_FETCH;
                ST_FETCH: begin
                    if (mem_ready)      state_q <= ST_DECODE;
                    else if (last_wait) state_q <= ST_FAULT;
                    else                cnt_q   <= cnt_q + CNT_W'(1);
                end
                ST_DECODE: begin
                    class_q <= decoded;
                    state_q <= (decoded == CLS_ILLEGAL) ? ST_FAULT : ST_EXEC;
                end
                ST_EXEC: begin
                    case (class_q)
                        CLS_R, CLS_OPIMM, CLS_AUIPC:            state_q <= ST_WB;
                        CLS_LOAD, CLS_STORE:                    state_q <= ST_MEM;
                        CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_LUI: state_q <= ST_FETCH;
                        default:                                state_q <= ST_FAULT;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready)      state_q <= (class_q == CLS_LOAD) ? ST_WB : ST_FETCH;
                    else if (last_wait) state_q <= ST_FAULT;
                    else                cnt_q   <= cnt_q + CNT_W'(1);
                end
                ST_WB:    state_q <= ST_FETCH;
                ST_FAULT: state_q <= ST_FAULT;
                default:  state_q <= ST_FAULT;
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        alu_src_a = SRCA_RS1;
        alu_src_b = 1'b0;
        alu_op    = ALU_ADD;
        reg_we    = 1'b0;
        wb_sel    = WB_ALU;
        fault     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_sel = PC_PLUS4;
                end
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_R:     alu_op = ALU_FUNCT;
                    CLS_OPIMM: begin
                        alu_src_b = 1'b1;
                        alu_op    = ALU_FUNCT;
                    end
                    CLS_LOAD, CLS_STORE: alu_src_b = 1'b1;
                    CLS_BRANCH: begin
                        alu_op = ALU_CMP;
                        pc_we  = branch_taken;
                        pc_sel = PC_TARGET;
                    end
                    CLS_JAL: begin
                        pc_we  = 1'b1;
                        pc_sel = PC_TARGET;
                        reg_we = 1'b1;
                        wb_sel = WB_PC;
                    end
                    CLS_JALR: begin
                        alu_src_b = 1'b1;
                        pc_we     = 1'b1;
                        pc_sel    = PC_ALU;
                        reg_we    = 1'b1;
                        wb_sel    = WB_PC;
                    end
                    CLS_LUI: begin
                        reg_we = 1'b1;
                        wb_sel = WB_IMM;
                    end
                    CLS_AUIPC: begin
                        alu_src_a = SRCA_PC;
                        alu_src_b = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (class_q == CLS_STORE);
            end
            ST_WB: begin
                reg_we = 1'b1;
                wb_sel = (class_q == CLS_LOAD) ? WB_MDR : WB_ALU;
            end
            ST_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected outputs come
// from a phase-list model of each instruction built from the controller rules.
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       fault;
    } outs_t;

    typedef struct {
        logic [6:0] opcode;
        logic       ready;
        logic       taken;
        outs_t      exp;
    } vec_t;

    localparam logic [6:0] R_OP     = 7'h33;
    localparam logic [6:0] IMM_OP   = 7'h13;
    localparam logic [6:0] LD_OP    = 7'h03;
    localparam logic [6:0] ST_OP    = 7'h23;
    localparam logic [6:0] BR_OP    = 7'h63;
    localparam logic [6:0] JAL_OP   = 7'h6f;
    localparam logic [6:0] JALR_OP  = 7'h67;
    localparam logic [6:0] LUI_OP   = 7'h37;
    localparam logic [6:0] AUIPC_OP = 7'h17;
    localparam int         TMO      = 4;

    logic       clk = 1'b0;
    logic       rst_n, rst_n_nx;
    logic [6:0] opcode, opcode_nx;
    logic       mem_ready, ready_nx, branch_taken, taken_nx;

    logic       mem_req, mem_we, addr_sel, ir_we, pc_we, alu_src_b, reg_we, fault;
    logic [1:0] pc_sel, alu_src_a, alu_op, wb_sel;
    logic [2:0] state;
    logic       mem_req_nx, mem_we_nx, addr_sel_nx, ir_we_nx, pc_we_nx, alu_src_b_nx, reg_we_nx, fault_nx;
    logic [1:0] pc_sel_nx, alu_src_a_nx, alu_op_nx, wb_sel_nx;
    logic [2:0] state_nx;

    outs_t act, act_nx;
    assign act = {state, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel,
                  alu_src_a, alu_src_b, alu_op, reg_we, wb_sel, fault};
    assign act_nx = {state_nx, mem_req_nx, mem_we_nx, addr_sel_nx, ir_we_nx, pc_we_nx, pc_sel_nx,
                     alu_src_a_nx, alu_src_b_nx, alu_op_nx, reg_we_nx, wb_sel_nx, fault_nx};

    multicycle_control #(.ENABLE_EXT(1'b1), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_we(reg_we), .wb_sel(wb_sel), .fault(fault), .state(state)
    );

    multicycle_control #(.ENABLE_EXT(1'b0), .TIMEOUT(16)) dut_nx (
        .clk(clk), .rst_n(rst_n_nx), .opcode(opcode_nx), .mem_ready(ready_nx),
        .branch_taken(taken_nx), .mem_req(mem_req_nx), .mem_we(mem_we_nx),
        .addr_sel(addr_sel_nx), .ir_we(ir_we_nx), .pc_we(pc_we_nx), .pc_sel(pc_sel_nx),
        .alu_src_a(alu_src_a_nx), .alu_src_b(alu_src_b_nx), .alu_op(alu_op_nx),
        .reg_we(reg_we_nx), .wb_sel(wb_sel_nx), .fault(fault_nx), .state(state_nx)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    vec_t       q[$];
    vec_t       tbl[6];
    bit         dead;
    logic [6:0] legal_ops[9];

    task automatic check(input string name, input outs_t actual, input outs_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %b (state %0d), expected %b (state %0d)",
                     name, actual, actual.state, expected, expected.state);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic outs_t base(input logic [2:0] st);
        outs_t r;
        r = '0;
        r.state = st;
        return r;
    endfunction

    function automatic vec_t rec(input logic [6:0] op, input logic rdy, input logic tk, input outs_t e);
        vec_t v;
        v.opcode = op;
        v.ready  = rdy;
        v.taken  = tk;
        v.exp    = e;
        return v;
    endfunction

    task automatic begin_seq();
        q.delete();
        dead = 1'b0;
        q.push_back(rec(7'($urandom), rbit(), rbit(), base(3'd0)));
    endtask

    // One memory access held for `waits` low-ready cycles; TMO or more waits trap.
    task automatic push_access(input bit is_mem, input bit store, input int waits,
                               input logic [6:0] op, output bit timed_out);
        outs_t e;
        e = base(is_mem ? 3'd4 : 3'd1);
        e.mem_req  = 1'b1;
        e.addr_sel = is_mem;
        e.mem_we   = is_mem & store;
        timed_out  = (waits >= TMO);
        for (int i = 0; i < (timed_out ? TMO : waits); i++)
            q.push_back(rec(is_mem ? op : 7'($urandom), 1'b0, rbit(), e));
        if (!timed_out) begin
            if (!is_mem) begin
                e.ir_we = 1'b1;
                e.pc_we = 1'b1;
            end
            q.push_back(rec(is_mem ? op : 7'($urandom), 1'b1, rbit(), e));
        end
    endtask

    task automatic add_instr(input logic [6:0] op, input int fw, input int mw,
                             input logic tk, input bit ext);
        outs_t e;
        bit    to, legal, needs_wb;
        if (dead) return;
        push_access(1'b0, 1'b0, fw, op, to);
        if (to) begin
            dead = 1'b1;
            return;
        end
        q.push_back(rec(op, rbit(), rbit(), base(3'd2)));
        e        = base(3'd3);
        legal    = 1'b1;
        needs_wb = 1'b0;
        case (op)
            R_OP: begin
                e.alu_op = 2'b10;
                needs_wb = 1'b1;
            end
            LD_OP, ST_OP: e.alu_src_b = 1'b1;
            BR_OP: begin
                e.alu_op = 2'b01;
                e.pc_we  = tk;
                e.pc_sel = 2'b01;
            end
            IMM_OP: if (ext) begin
                e.alu_op    = 2'b10;
                e.alu_src_b = 1'b1;
                needs_wb    = 1'b1;
            end else legal = 1'b0;
            JAL_OP: if (ext) begin
                e.pc_we  = 1'b1;
                e.pc_sel = 2'b01;
                e.reg_we = 1'b1;
                e.wb_sel = 2'b10;
            end else legal = 1'b0;
            JALR_OP: if (ext) begin
                e.alu_src_b = 1'b1;
                e.pc_we     = 1'b1;
                e.pc_sel    = 2'b10;
                e.reg_we    = 1'b1;
                e.wb_sel    = 2'b10;
            end else legal = 1'b0;
            LUI_OP: if (ext) begin
                e.reg_we = 1'b1;
                e.wb_sel = 2'b11;
            end else legal = 1'b0;
            AUIPC_OP: if (ext) begin
                e.alu_src_a = 2'b01;
                e.alu_src_b = 1'b1;
                needs_wb    = 1'b1;
            end else legal = 1'b0;
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dead = 1'b1;
            return;
        end
        q.push_back(rec(op, rbit(), (op == BR_OP) ? tk : rbit(), e));
        if (op == LD_OP || op == ST_OP) begin
            push_access(1'b1, op == ST_OP, mw, op, to);
            if (to) begin
                dead = 1'b1;
                return;
            end
            needs_wb = (op == LD_OP);
        end
        if (needs_wb) begin
            e        = base(3'd5);
            e.reg_we = 1'b1;
            e.wb_sel = (op == LD_OP) ? 2'b01 : 2'b00;
            q.push_back(rec(op, rbit(), rbit(), e));
        end
    endtask

    // A trapped run must stay in FAULT; a live one must be back in FETCH.
    task automatic finish_seq();
        outs_t e;
        if (dead) begin
            e = base(3'd7);
            e.fault = 1'b1;
            for (int i = 0; i < 10; i++) q.push_back(rec(7'($urandom), rbit(), rbit(), e));
        end else begin
            e = base(3'd1);
            e.mem_req = 1'b1;
            q.push_back(rec(7'($urandom), 1'b0, rbit(), e));
        end
    endtask

    task automatic run_queue(input string name, input bit nx);
        for (int i = 0; i < q.size(); i++) begin
            if (nx) begin
                opcode_nx = q[i].opcode;
                ready_nx  = q[i].ready;
                taken_nx  = q[i].taken;
            end else begin
                opcode       = q[i].opcode;
                mem_ready    = q[i].ready;
                branch_taken = q[i].taken;
            end
            #1;
            check($sformatf("%s[%0d]", name, i), nx ? act_nx : act, q[i].exp);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input bit nx);
        if (nx) rst_n_nx = 1'b0;
        else    rst_n    = 1'b0;
        @(posedge clk);
        #1;
        check(nx ? "reset_nx" : "reset", nx ? act_nx : act, base(3'd0));
        @(posedge clk);
        #1;
        if (nx) rst_n_nx = 1'b1;
        else    rst_n    = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        outs_t e;
        rst_n = 1'b0;  rst_n_nx = 1'b0;
        opcode = '0;   opcode_nx = '0;
        mem_ready = 1'b0; ready_nx = 1'b0;
        branch_taken = 1'b0; taken_nx = 1'b0;
        legal_ops = '{R_OP, IMM_OP, LD_OP, ST_OP, BR_OP, JAL_OP, JALR_OP, LUI_OP, AUIPC_OP};
        @(posedge clk);
        #1;

        // Fixed vector table: R-type with ready tied high, states 0,1,2,3,5,1.
        tbl[0] = rec(R_OP, 1'b1, 1'b0, '{state: 3'd0, default: '0});
        tbl[1] = rec(R_OP, 1'b1, 1'b0, '{state: 3'd1, mem_req: 1'b1, ir_we: 1'b1, pc_we: 1'b1, default: '0});
        tbl[2] = rec(R_OP, 1'b1, 1'b0, '{state: 3'd2, default: '0});
        tbl[3] = rec(R_OP, 1'b1, 1'b0, '{state: 3'd3, alu_op: 2'b10, default: '0});
        tbl[4] = rec(R_OP, 1'b1, 1'b0, '{state: 3'd5, reg_we: 1'b1, default: '0});
        tbl[5] = rec(R_OP, 1'b1, 1'b0, '{state: 3'd1, mem_req: 1'b1, ir_we: 1'b1, pc_we: 1'b1, default: '0});
        do_reset(1'b0);
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(tbl[i]);
        run_queue("rtype_table", 1'b0);

        // LOAD with two MEM wait cycles, then WB from MDR.
        do_reset(1'b0);
        begin_seq();
        add_instr(LD_OP, 0, 2, 1'b0, 1'b1);
        finish_seq();
        run_queue("load_wait2", 1'b0);

        // BRANCH not taken then taken.
        do_reset(1'b0);
        begin_seq();
        add_instr(BR_OP, 0, 0, 1'b0, 1'b1);
        add_instr(BR_OP, 0, 0, 1'b1, 1'b1);
        finish_seq();
        run_queue("branch", 1'b0);

        // Fetch timeout after exactly TMO waits, and ready on the last wait cycle.
        do_reset(1'b0);
        begin_seq();
        add_instr(R_OP, TMO, 0, 1'b0, 1'b1);
        finish_seq();
        run_queue("fetch_timeout", 1'b0);
        do_reset(1'b0);
        begin_seq();
        add_instr(R_OP, TMO - 1, 0, 1'b0, 1'b1);
        add_instr(ST_OP, 0, TMO - 1, 1'b0, 1'b1);
        finish_seq();
        run_queue("ready_at_limit", 1'b0);
        do_reset(1'b0);
        begin_seq();
        add_instr(LD_OP, 1, TMO, 1'b0, 1'b1);
        finish_seq();
        run_queue("mem_timeout", 1'b0);

        // Reset asserted while a STORE is waiting in MEM.
        do_reset(1'b0);
        begin_seq();
        add_instr(ST_OP, 0, 3, 1'b0, 1'b1);
        while (q.size() > 6) void'(q.pop_back());
        run_queue("store_pre", 1'b0);
        mem_ready = 1'b0;
        #1;
        e = base(3'd4);
        e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = 1'b1;
        check("store_in_mem", act, e);
        rst_n = 1'b0;
        #1;
        check("store_async_reset", act, base(3'd0));
        do_reset(1'b0);
        begin_seq();
        finish_seq();
        run_queue("after_reset", 1'b0);

        // Randomized legal instruction stream with short waits.
        do_reset(1'b0);
        begin_seq();
        for (int n = 0; n < 40; n++)
            add_instr(legal_ops[$urandom_range(8)], int'($urandom_range(3)),
                      int'($urandom_range(3)), rbit(), 1'b1);
        finish_seq();
        run_queue("random", 1'b0);

        // Extended opcodes are illegal without ENABLE_EXT; the trap is sticky.
        do_reset(1'b1);
        begin_seq();
        add_instr(R_OP, 1, 0, 1'b0, 1'b0);
        add_instr(JAL_OP, 0, 0, 1'b0, 1'b0);
        finish_seq();
        run_queue("noext_jal", 1'b1);
        rst_n_nx = 1'b0;
        #1;
        check("noext_async_reset", act_nx, base(3'd0));
        do_reset(1'b1);
        begin_seq();
        add_instr(IMM_OP, 0, 0, 1'b0, 1'b0);
        finish_seq();
        run_queue("noext_opimm", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM for the RV32I datapath, succeeding the single-cycle opcode decoder. It sequences fetch, decode, execute, memory and writeback over several cycles, sharing one memory port and one ALU. It waits on a memory ready handshake and traps on memory timeout or illegal opcodes. It sits between the instruction register / branch comparator and the datapath mux selects and write enables.

## Interface
- ENABLE_EXT, 1: 1 decodes OP-IMM, LUI, AUIPC, JAL, JALR in addition to R/LOAD/STORE/BRANCH; 0 treats those opcodes as illegal.
- TIMEOUT, 16: maximum consecutive cycles with mem_ready low in one access before fault; legal range 1..255.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- mem_ready  in  1  memory has completed the current request this cycle.
- branch_taken  in  1  datapath branch-condition result, valid in EXEC.
- mem_req  out  1  memory request strobe.
- mem_we  out  1  write qualifier for mem_req.
- addr_sel  out  1  memory address: 0 PC, 1 ALUOut.
- ir_we  out  1  load IR and old_pc.
- pc_we  out  1  PC write enable.
- pc_sel  out  2  00 PC+4, 01 old_pc+imm, 10 ALU result with bit0 cleared.
- alu_src_a  out  2  00 rs1, 01 old_pc, 10 zero.
- alu_src_b  out  1  0 rs2, 1 imm.
- alu_op  out  2  00 add, 01 compare/sub, 10 funct-decoded.
- reg_we  out  1  register file write.
- wb_sel  out  2  00 ALUOut, 01 MDR, 10 PC (already incremented), 11 imm.
- fault  out  1  sticky trap flag.
- state  out  3  current state, debug.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7.
- IDLE: all strobes 0; next FETCH.
- FETCH: mem_req=1, addr_sel=0. If mem_ready: ir_we=1, pc_we=1, pc_sel=00, next DECODE. Otherwise stay.
- DECODE: register class = classify(opcode). Illegal class goes to FAULT, otherwise EXEC. Strobes 0.
- EXEC, by class:
  - R: alu_src_a=00, alu_src_b=0, alu_op=10; next WB.
  - OP-IMM: as R but alu_src_b=1; next WB.
  - LOAD/STORE: alu_src_b=1, alu_op=00; next MEM.
  - BRANCH: alu_src_b=0, alu_op=01. pc_we=branch_taken, pc_sel=01; next FETCH.
  - JAL: pc_we=1, pc_sel=01, reg_we=1, wb_sel=10; next FETCH.
  - JALR: alu_src_b=1, alu_op=00, pc_we=1, pc_sel=10, reg_we=1, wb_sel=10; next FETCH.
  - LUI: reg_we=1, wb_sel=11; next FETCH.
  - AUIPC: alu_src_a=01, alu_src_b=1, alu_op=00; next WB.
- MEM: mem_req=1, addr_sel=1, mem_we=(class==STORE). On mem_ready: LOAD goes to WB, STORE goes to FETCH.
- WB: reg_we=1, wb_sel=01 for LOAD, else 00; next FETCH.
- Timeout: counter cleared on entry to FETCH/MEM and incremented each cycle mem_ready is low. When the counter reaches TIMEOUT, next state is FAULT. mem_ready high on the same edge wins.
- FAULT: all strobes 0, fault=1; exit only by reset.
- Unused select outputs are 0 in every state.

## Timing
- Reset (async assert): state=IDLE; every output 0; class register = R; counter=0.
- Deassertion is synchronised externally; the first FETCH is one cycle after the first clk edge.
- Outputs are combinational from state and class; mem_ready and branch_taken gate strobes in the same cycle.
- Latency with zero wait states, counting FETCH through return to FETCH:
  - R/OP-IMM/AUIPC/LOAD-less: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH/JAL/JALR/LUI: 3 cycles.
- Each wait cycle adds 1.
- Reset mid-access: immediate return to IDLE; mem_req drops asynchronously.

## Structure
- Package ctrl_pkg holds:
  - state enum;
  - opcode localparams (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111);
  - class enum including ILLEGAL;
  - pc_sel, wb_sel, alu_op and alu_src_a encodings.
- Sub-module opcode_classifier: combinational, opcode + ENABLE_EXT to class.
- Counter width is $clog2(TIMEOUT+1).

## Test plan
- Reset, then R-type 0110011 with mem_ready tied 1: states 0,1,2,3,5,1; reg_we=1 and wb_sel=00 only in WB.
- LOAD 0000011 with 2 wait cycles in MEM: MEM held 3 cycles with mem_req=1, addr_sel=1, mem_we=0; then WB with wb_sel=01.
- BRANCH with branch_taken=0 then 1: pc_we stays 0, then pc_we=1 with pc_sel=01; both return to FETCH after 3 cycles.
- ENABLE_EXT=0 and opcode 1101111: DECODE goes to FAULT, fault=1 and sticky across 10 cycles, cleared only by rst_n.
- TIMEOUT=4 with mem_ready low in FETCH: FAULT entered after exactly 4 wait cycles. A repeat with ready on the 4th cycle proceeds to DECODE.
- rst_n pulsed low during MEM of a STORE: mem_req and mem_we drop immediately, state=0, and the next access is a FETCH.
